// File: rtl/dma_arb_pkg.sv
// Shared types for the DMA/CPU system-bus arbiter.
// The optional CPU fairness slot is controlled by DMA_ARB_CPU_FAIRNESS_EN.
package dma_arb_pkg;

    localparam int NUM_DMA_CH = 4;

    typedef logic [1:0] dma_id_t;

    typedef enum logic [1:0] {
        CPU,
        SWITCH,
        DMA,
        CPU_SLOT
    } arb_state_t;

    // What the SWITCH state hands the bus to once the turnaround expires.
    typedef enum logic [1:0] {
        TGT_CPU,
        TGT_SLOT,
        TGT_CH
    } tgt_kind_t;

    typedef struct packed {
        tgt_kind_t kind;
        dma_id_t   ch;
    } switch_tgt_t;

    function automatic logic [NUM_DMA_CH-1:0] id_to_onehot(input dma_id_t id);
        logic [NUM_DMA_CH-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/prio_enc4.sv
// Fixed-priority encoder: lowest set request index wins.
module prio_enc4
    import dma_arb_pkg::*;
(
    input  logic [NUM_DMA_CH-1:0] req,
    output dma_id_t               idx,
    output logic                  valid
);

    // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = NUM_DMA_CH - 1; i >= 0; i--) begin
            if (req[i]) idx = dma_id_t'(i);
        end
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Hands the shared system bus between the CPU and four DMA channels with a dead-bus turnaround.
// Define DMA_ARB_CPU_FAIRNESS_EN to give the CPU one slot after every MAX_UNITS DMA units.
module dma_bus_arbiter
    import dma_arb_pkg::*;
#(
    parameter int TURNAROUND = 1,
    parameter int MAX_UNITS  = 16,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_DMA_CH-1:0] dma_req,
    input  logic [NUM_DMA_CH-1:0] dma_boundary,
    input  logic                  cpu_req,
    input  logic                  mem_wait,
    output logic [NUM_DMA_CH-1:0] dma_grant,
    output logic                  cpu_grant,
    output logic                  dma_active,
    output dma_id_t               owner_id
);

    if (TURNAROUND < 1 || TURNAROUND > 7) begin : g_turn_check
        $error("TURNAROUND must be in 1..7");
    end
    if (CNT_W < $clog2(MAX_UNITS + 1)) begin : g_cnt_check
        $error("CNT_W too narrow for MAX_UNITS");
    end

    localparam logic [2:0] TURN_LAST = 3'(TURNAROUND - 1);

    arb_state_t  state, next_state;
    switch_tgt_t tgt, next_tgt;
    switch_tgt_t fallback_tgt, resolved_tgt;
    logic [2:0]  turn_cnt, next_turn;
    dma_id_t     next_owner;
    dma_id_t     best;
    logic        best_v;
    logic        fair_trip;

    prio_enc4 u_best (
        .req   (dma_req),
        .idx   (best),
        .valid (best_v)
    );

`ifdef DMA_ARB_CPU_FAIRNESS_EN
    logic [CNT_W-1:0] unit_cnt, cnt_inc;
    logic             unit_step;

    assign unit_step = (state == DMA) && dma_boundary[owner_id] && !mem_wait;
    assign cnt_inc   = (unit_cnt == CNT_W'(MAX_UNITS)) ? unit_cnt : unit_cnt + CNT_W'(1);
    // Trips on the unit that brings the count to MAX_UNITS, not one later.
    assign fair_trip = (cnt_inc == CNT_W'(MAX_UNITS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            unit_cnt <= '0;
        end else if (next_state == CPU || next_state == CPU_SLOT) begin
            unit_cnt <= '0;
        end else if (unit_step) begin
            unit_cnt <= cnt_inc;
        end
    end
`else
    assign fair_trip = 1'b0;
`endif

    always_comb begin
        fallback_tgt.kind = best_v ? TGT_CH : TGT_CPU;
        fallback_tgt.ch   = best_v ? best : dma_id_t'(0);

        // A pending channel target follows the current best request until expiry.
        resolved_tgt = tgt;
        if (tgt.kind == TGT_CH) resolved_tgt = fallback_tgt;

        next_state = state;
        next_tgt   = tgt;
        next_turn  = '0;
        next_owner = owner_id;

        case (state)
            CPU: begin
                if (best_v && !mem_wait) begin
                    next_state  = SWITCH;
                    next_tgt.kind = TGT_CH;
                    next_tgt.ch   = best;
                end
            end
            SWITCH: begin
                next_tgt = resolved_tgt;
                if (turn_cnt == TURN_LAST) begin
                    case (resolved_tgt.kind)
                        TGT_CH: begin
                            next_state = DMA;
                            next_owner = resolved_tgt.ch;
                        end
                        TGT_SLOT: next_state = CPU_SLOT;
                        default:  next_state = CPU;
                    endcase
                end else begin
                    next_turn = turn_cnt + 3'd1;
                end
            end
            DMA: begin
                if (dma_boundary[owner_id] && !mem_wait) begin
                    if (fair_trip && cpu_req) begin
                        next_state    = SWITCH;
                        next_tgt.kind = TGT_SLOT;
                        next_tgt.ch   = owner_id;
                    end else if (best_v && best != owner_id) begin
                        next_state    = SWITCH;
                        next_tgt.kind = TGT_CH;
                        next_tgt.ch   = best;
                    end else if (!best_v) begin
                        next_state    = SWITCH;
                        next_tgt.kind = TGT_CPU;
                        next_tgt.ch   = '0;
                    end
                end else if (!dma_req[owner_id] && !mem_wait) begin
                    // Channel disabled by software mid-unit.
                    next_state = SWITCH;
                    next_tgt   = fallback_tgt;
                end
            end
            CPU_SLOT: begin
                if (!cpu_req || !mem_wait) begin
                    next_state = SWITCH;
                    next_tgt   = fallback_tgt;
                end
            end
            default: next_state = CPU;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CPU;
            tgt.kind  <= TGT_CPU;
            tgt.ch    <= '0;
            turn_cnt  <= '0;
            owner_id  <= '0;
            cpu_grant <= 1'b1;
            dma_grant <= '0;
        end else begin
            state     <= next_state;
            tgt       <= next_tgt;
            turn_cnt  <= next_turn;
            owner_id  <= next_owner;
            cpu_grant <= (next_state == CPU) || (next_state == CPU_SLOT);
            dma_grant <= (next_state == DMA) ? id_to_onehot(next_owner) : '0;
        end
    end

    assign dma_active = |dma_grant;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Scoreboard bench for dma_bus_arbiter (TURNAROUND=1, MAX_UNITS=4).
// Fairness expectations follow DMA_ARB_CPU_FAIRNESS_EN.
module tb_dma_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dma_req;
    logic [3:0] dma_boundary;
    logic       cpu_req;
    logic       mem_wait;
    logic [3:0] dma_grant;
    logic       cpu_grant;
    logic       dma_active;
    logic [1:0] owner_id;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic       cg;
        logic [3:0] dg;
        logic [1:0] oid;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    dma_bus_arbiter #(
        .TURNAROUND (1),
        .MAX_UNITS  (4),
        .CNT_W      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dma_req      (dma_req),
        .dma_boundary (dma_boundary),
        .cpu_req      (cpu_req),
        .mem_wait     (mem_wait),
        .dma_grant    (dma_grant),
        .cpu_grant    (cpu_grant),
        .dma_active   (dma_active),
        .owner_id     (owner_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic compare_outputs(input string tag, input exp_t e);
        check({tag, ".cpu_grant"}, 32'(cpu_grant), 32'(e.cg));
        check({tag, ".dma_grant"}, 32'(dma_grant), 32'(e.dg));
        check({tag, ".owner_id"},  32'(owner_id),  32'(e.oid));
        check({tag, ".dma_active"}, 32'(dma_active), 32'(|e.dg));
        check({tag, ".exclusive"}, 32'(cpu_grant & dma_active), 32'(0));
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the next edge, then compare.
    task automatic cycle(input logic [3:0] req, input logic [3:0] bnd, input logic creq,
                         input logic mw, input string tag,
                         input logic cg, input logic [3:0] dg, input logic [1:0] oid);
        exp_t e;
        dma_req      = req;
        dma_boundary = bnd;
        cpu_req      = creq;
        mem_wait     = mw;
        e.cg = cg; e.dg = dg; e.oid = oid;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare_outputs(tag_q.pop_front(), exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; dma_req = '0; dma_boundary = '0; cpu_req = 1'b0; mem_wait = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare_outputs("reset_held", '{1'b1, 4'b0000, 2'd0});
        @(negedge clk);
        rst = 1'b0;
        #1;
        compare_outputs("reset_release", '{1'b1, 4'b0000, 2'd0});

        // Idle, then grant to channel 2
        cycle(4'b0000, 4'b0000, 0, 0, "idle",        1, 4'b0000, 2'd0);
        cycle(4'b0100, 4'b0000, 0, 0, "grant_turn",  0, 4'b0000, 2'd0);
        cycle(4'b0100, 4'b0000, 0, 0, "grant_ch2",   0, 4'b0100, 2'd2);

        // Higher-priority request mid-unit does not preempt
        cycle(4'b0101, 4'b0000, 0, 0, "nopreempt0",  0, 4'b0100, 2'd2);
        cycle(4'b0101, 4'b0000, 0, 0, "nopreempt1",  0, 4'b0100, 2'd2);
        cycle(4'b0101, 4'b0100, 0, 0, "handoff_gap", 0, 4'b0000, 2'd2);
        cycle(4'b0101, 4'b0000, 0, 0, "handoff_ch0", 0, 4'b0001, 2'd0);

        // Boundary stalled by mem_wait; dropped request cannot release either while stalled
        for (int i = 0; i < 3; i++)
            cycle(4'b0100, 4'b0001, 0, 1, $sformatf("stall%0d", i), 0, 4'b0001, 2'd0);
        cycle(4'b0100, 4'b0001, 0, 0, "stall_release", 0, 4'b0000, 2'd0);
        // Turnaround counts through mem_wait
        cycle(4'b0100, 4'b0000, 0, 1, "switch_wait",  0, 4'b0100, 2'd2);

        // Software disable: ch2 drops for ch1, then ch1 drops with nothing pending
        cycle(4'b0010, 4'b0000, 0, 0, "disable_gap",  0, 4'b0000, 2'd2);
        cycle(4'b0010, 4'b0000, 0, 0, "disable_ch1",  0, 4'b0010, 2'd1);
        cycle(4'b0000, 4'b0000, 0, 0, "disable_off",  0, 4'b0000, 2'd1);
        cycle(4'b0000, 4'b0000, 0, 0, "disable_cpu",  1, 4'b0000, 2'd1);

        // Fairness: ch3 streaming units with CPU waiting
        cycle(4'b1000, 4'b0000, 1, 0, "fair_turn",    0, 4'b0000, 2'd1);
        cycle(4'b1000, 4'b0000, 1, 0, "fair_ch3",     0, 4'b1000, 2'd3);
        for (int i = 1; i <= 3; i++)
            cycle(4'b1000, 4'b1000, 1, 0, $sformatf("fair_unit%0d", i), 0, 4'b1000, 2'd3);
`ifdef DMA_ARB_CPU_FAIRNESS_EN
        cycle(4'b1000, 4'b1000, 1, 0, "fair_unit4",   0, 4'b0000, 2'd3);
        cycle(4'b1000, 4'b0000, 1, 0, "fair_slot",    1, 4'b0000, 2'd3);
        cycle(4'b1000, 4'b0000, 1, 0, "fair_back",    0, 4'b0000, 2'd3);
        cycle(4'b1000, 4'b0000, 1, 0, "fair_ch3_again", 0, 4'b1000, 2'd3);
`else
        cycle(4'b1000, 4'b1000, 1, 0, "fair_unit4",   0, 4'b1000, 2'd3);
        for (int i = 0; i < 3; i++)
            cycle(4'b1000, 4'b0000, 1, 0, $sformatf("nofair%0d", i), 0, 4'b1000, 2'd3);
`endif

        // Boundary coinciding with new higher-priority requests: lowest index wins
        cycle(4'b1111, 4'b1000, 0, 0, "prio_gap",     0, 4'b0000, 2'd3);
        cycle(4'b1111, 4'b0000, 0, 0, "prio_ch0",     0, 4'b0001, 2'd0);
        cycle(4'b1111, 4'b0000, 0, 0, "prio_hold",    0, 4'b0001, 2'd0);

        // Asynchronous reset mid-transfer, away from any clock edge
        #2;
        rst = 1'b1;
        #1;
        compare_outputs("async_reset", '{1'b1, 4'b0000, 2'd0});
        @(negedge clk);
        rst = 1'b0;
        cycle(4'b0000, 4'b0000, 0, 0, "post_reset",   1, 4'b0000, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Sequences ownership of the shared system bus (addr/wdata/rdata/size/wen) between the CPU and the four DMA channels. It grants the bus to exactly one master at a time, using fixed priority with channel 0 highest. A DMA owner is switched only at a unit boundary, and every ownership change inserts a configurable dead-bus turnaround. It sits between the four DMA channel units and the memory interface, alongside the CPU bus interface.

## Interface
- TURNAROUND, 1: idle cycles with no grant between any two owners; legal range 1..7.
- MAX_UNITS, 16: DMA units after which the CPU is given one access slot (fairness only).
- CNT_W, 8: width of the unit counter; must hold MAX_UNITS.
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- dma_req  input  4  channel n has a pending or in-progress transfer (level).
- dma_boundary  input  4  channel n has completed a unit (write accepted this cycle); sampled only for the current owner.
- cpu_req  input  1  CPU has a pending bus access (level).
- mem_wait  input  1  memory is stalling the current access.
- dma_grant  output  4  one-hot, or zero; registered.
- cpu_grant  output  1  CPU owns the bus; registered.
- dma_active  output  1  equals |dma_grant.
- owner_id  output  2  index of the granted or last-granted channel.

## Operation
- States: CPU, SWITCH, DMA, CPU_SLOT. SWITCH holds a registered target: CPU, CPU_SLOT, or a channel index.
- best = lowest set index of dma_req; best_v = |dma_req.
- CPU: cpu_grant=1. If best_v and ~mem_wait, go to SWITCH with target=best. Stay while mem_wait is high, because a CPU access is in flight.
- SWITCH: no grant is asserted.
  - A turn counter runs TURNAROUND cycles.
  - A channel target is re-resolved each cycle to best. If best_v drops, the target becomes CPU.
  - On expiry, go to the target state. A channel target sets dma_grant[target] and owner_id.
- DMA, on a cycle with dma_boundary[owner] & ~mem_wait:
  - Increment the unit counter.
  - If fairness trips and cpu_req is high, go to SWITCH with target CPU_SLOT.
  - Otherwise, if best_v and best≠owner, go to SWITCH with target=best.
  - Otherwise, if best==owner, stay.
  - Otherwise, go to SWITCH with target CPU.
- DMA, no boundary:
  - The grant holds regardless of other requests. There is no mid-unit preemption.
  - Exception: if ~dma_req[owner] and ~mem_wait (channel disabled by software), go to SWITCH with target=best, or CPU if none.
- CPU_SLOT: cpu_grant=1. Leave on the first cycle where (cpu_req & ~mem_wait) or ~cpu_req, going to SWITCH with target=best, or CPU if none.
- Unit counter:
  - Cleared on entry to CPU or CPU_SLOT.
  - Not cleared on DMA-to-DMA handoff.
  - Saturates at MAX_UNITS.
  - Fairness trips when the counter equals MAX_UNITS.
- Simultaneous owner boundary and new higher-priority request: the boundary decision sees the new request and hands off.
- Simultaneous owner boundary and owner dma_req falling: treated as a completed transfer.

## Timing
- Reset values:
  - state CPU, cpu_grant=1, dma_grant=0000, dma_active=0, owner_id=0.
  - Unit and turn counters 0; SWITCH target CPU.
- Asserting rst mid-transfer forces the reset values immediately, asynchronously. No partial unit is preserved.
- Request latency from CPU state: dma_req seen at cycle t with mem_wait=0 gives cpu_grant=0 at t+1 and dma_grant at t+1+TURNAROUND.
- Handoff latency: owner boundary at cycle u gives dma_grant=0 at u+1 and the new grant at u+1+TURNAROUND.
- Grants never overlap. cpu_grant and dma_active are never both 1.
- mem_wait high freezes all ownership transitions except SWITCH counting. SWITCH has no access in flight, so it counts through mem_wait.

## Configuration
- DMA_ARB_CPU_FAIRNESS_EN defined:
  - Unit counter present.
  - MAX_UNITS enforced.
  - CPU_SLOT reachable.
- DMA_ARB_CPU_FAIRNESS_EN undefined:
  - Counter removed; fairness never trips.
  - CPU_SLOT unreachable; the enum value is retained.
  - DMA keeps the bus until no channel requests.

## Structure
- Package dma_arb_pkg:
  - State enum arb_state_t {CPU, SWITCH, DMA, CPU_SLOT}.
  - Target kind enum.
  - NUM_DMA_CH=4.
  - typedef dma_id_t (2 bits).
- Sub-module prio_enc4 (combinational): 4-bit request in; lowest index and valid out. Instantiated once for best.

## Test plan
- Reset: hold rst for 3 cycles, then release -> cpu_grant=1, dma_grant=0000, owner_id=0, dma_active=0.
- Grant, TURNAROUND=1: dma_req=0100 at t, mem_wait=0 -> cpu_grant=0 at t+1, dma_grant=0100 and owner_id=2 at t+2.
- No mid-unit preemption: owner ch2, dma_req→0101 mid-unit -> dma_grant stays 0100 until dma_boundary[2] at u, then 0000 at u+1 and 0001 at u+2.
- mem_wait stall: boundary with mem_wait=1 for 3 cycles -> no handoff until the first boundary cycle with mem_wait=0.
- Fairness (macro on), MAX_UNITS=4: ch3 requesting continuously and cpu_req=1 -> after the 4th boundary, cpu_grant=1 for one access, then dma_grant=1000 again. With the macro off -> cpu_grant never asserts.
- Software disable: owner ch1 drops dma_req without a boundary, others 0 -> dma_grant=0000 next cycle, cpu_grant=1 TURNAROUND cycles later.
